instruction_fetch_queue: RTL and testbench

//  Fetch stage ahead of the ALU instruction decoder. Issues sequential word fetches
//  to instruction memory over a req/gnt + rvalid interface and buffers returned words

---
 rtl/instruction_fetch_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//   Fetch stage in front of the instruction decoder. It issues sequential word
//   fetches over a req/gnt + rvalid memory interface, buffers the returned words
//   together with their PC in a small FIFO, and hands one instruction per cycle
//   to the decoder over valid/ready.
//
//   A redirect flushes the FIFO and restarts fetch at the new PC. Responses
//   that are still in flight at that moment are counted in a discard counter
//   and dropped when they come back, so stale words never reach the decoder.
//
//   Credit rule: the number of FIFO entries plus the number of in-flight
//   requests never exceeds DEPTH. A kept response therefore always finds a free
//   slot, and the FIFO needs no overflow handling.
//
//   Optional feature: define IFQ_PERF_COUNTERS_EN to add the perf_fetched and
//   perf_stall counter outputs.
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef IFQ_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  // Pointer width, occupancy width (0..DEPTH), and credit-sum width (0..2*DEPTH).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = PW + 2;

  // Architectural state.
  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_started;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  // Per-cycle events.
  logic [SW-1:0] w_credit_sum;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_issue;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;

  // Decode the events of this cycle: issue, response retire and drop, push, pop.
  always_comb begin
    w_credit_sum = SW'(r_count) + SW'(r_outstanding);
    w_credit_ok  = (w_credit_sum < SW'(DEPTH));
    w_req        = r_started & ~redirect_valid & w_credit_ok;
    w_issue      = w_req & imem_gnt;
    // A response with nothing in flight is illegal and is ignored.
    w_resp       = imem_rvalid & (r_outstanding != {CW{1'b0}});
    w_drop       = w_resp & (r_discard != {CW{1'b0}});
    // A response arriving in the same cycle as a redirect is stale as well.
    w_push       = w_resp & ~w_drop & ~redirect_valid;
    w_valid      = (r_count != {CW{1'b0}}) & ~redirect_valid;
    w_pop        = w_valid & instr_ready;
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = w_valid;
  assign instruction = r_mem_data[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];

  // Fetch start flag: fetching begins on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Issue and response PCs: step by one word, or jump to the redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_resp_pc <= redirect_pc;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end else begin
        r_pc <= r_pc;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end else begin
        r_resp_pc <= r_resp_pc;
      end
    end
  end

  // In-flight request tracking: one up per grant, one down per retired response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= {CW{1'b0}};
    end else begin
      case ({w_issue, w_resp})
        2'b10:   r_outstanding <= r_outstanding + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_outstanding <= r_outstanding - {{(CW-1){1'b0}}, 1'b1};
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Stale-response counter: a redirect marks everything still in flight as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_discard <= {CW{1'b0}};
    end else if (redirect_valid) begin
      if (w_resp) begin
        r_discard <= r_outstanding - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_discard <= r_outstanding;
      end
    end else if (w_drop) begin
      r_discard <= r_discard - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_discard <= r_discard;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else if (redirect_valid) begin
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO storage: the kept response word and its PC, written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= 32'h0000_0000;
        r_mem_pc[i]   <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_resp_pc;
    end else begin
      r_mem_data[r_wr_ptr] <= r_mem_data[r_wr_ptr];
      r_mem_pc[r_wr_ptr]   <= r_mem_pc[r_wr_ptr];
    end
  end

`ifdef IFQ_PERF_COUNTERS_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Performance counters: words pushed, and cycles the decoder waited on an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0000_0000;
      r_perf_stall   <= 32'h0000_0000;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end else begin
        r_perf_fetched <= r_perf_fetched;
      end
      if (instr_ready & ~w_valid & r_started) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//   Randomized bench. The bench plays the instruction memory, with random grant
//   and random in-order response latency, and plays the decoder, with random
//   ready. A reference model tracks the decoder-visible queue as a list of PCs
//   and tags each in-flight request with a fetch epoch. A redirect starts a new
//   epoch, and only responses whose request epoch matches the current epoch are
//   kept. Directed phases cover fill latency, the credit limit, redirect with
//   stale responses, and reset mid-stream. Build with IFQ_PERF_COUNTERS_EN to
//   also check the performance counters.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef IFQ_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  // Reference model state.
  pend_t       pend_q[$];     // granted requests not yet answered, in order
  logic [31:0] fifo_q[$];     // PCs of entries visible to the decoder
  logic [31:0] m_pc;
  int          m_epoch;
  bit          m_started;

  // Stimulus knobs (percentages, and extra latency in cycles).
  int k_gnt, k_rv, k_rdy, k_redir, k_lat;
  bit hold_resp;
  bit f_redir;
  logic [31:0] f_redir_pc;

  // Bookkeeping.
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          n_pops;
  logic [31:0] g_addrs[$];
  logic [31:0] popped_q[$];

  // Contents of the instruction memory at a given word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0080_1234 ^ {a[15:0], a[31:16]} ^ (a << 3);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic run_cycle();
    bit          rv;
    bit          exp_req;
    bit          exp_valid;
    bit          pop;
    bit          push;
    pend_t       p;
    logic [31:0] rpc;
    @(negedge clk);
    cyc++;
    imem_gnt = ($urandom_range(99) < k_gnt);
    if (f_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_redir_pc;
    end else begin
      redirect_valid = ($urandom_range(99) < k_redir);
      rpc            = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_FFFC);
      redirect_pc    = rpc;
    end
    instr_ready = ($urandom_range(99) < k_rdy);
    rv = !hold_resp && (pend_q.size() > 0);
    if (rv) rv = (pend_q[0].due <= cyc) && ($urandom_range(99) < k_rv);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_q[0].addr) : $urandom();
    #1;
    exp_req = m_started && !redirect_valid && ((fifo_q.size() + pend_q.size()) < DEPTH);
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    exp_valid = (fifo_q.size() != 0) && !redirect_valid;
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check_eq("instr_pc", instr_pc, fifo_q[0]);
      check_eq("instruction", instruction, mem_word(fifo_q[0]));
    end
    pop  = exp_valid && instr_ready;
    push = 1'b0;
    if (rv) begin
      p    = pend_q.pop_front();
      push = !redirect_valid && (p.epoch == m_epoch);
    end
    if (pop) begin
      popped_q.push_back(fifo_q.pop_front());
      n_pops++;
    end
    if (push) fifo_q.push_back(p.addr);
    if (exp_req && imem_gnt) begin
      pend_q.push_back('{addr: m_pc, epoch: m_epoch, due: cyc + 1 + $urandom_range(0, k_lat)});
      g_addrs.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      fifo_q.delete();
      m_epoch++;
      m_pc = redirect_pc;
    end
  endtask

  // Asynchronous reset between clock edges, then a clean release.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instruction", instruction, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
    pend_q.delete(); fifo_q.delete();
    m_pc = RESET_PC; m_epoch++; m_started = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_req", {31'd0, imem_req}, 32'd0);
    m_started = 1'b1;           // the next edge starts fetching
    g_addrs.delete(); popped_q.delete(); n_pops = 0;
  endtask

  task automatic set_knobs(input int gnt, input int rv, input int rdy, input int redir, input int lat);
    k_gnt = gnt; k_rv = rv; k_rdy = rdy; k_redir = redir; k_lat = lat;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; m_epoch = 0;
    rst_n = 1'b0; hold_resp = 1'b0; f_redir = 1'b0; f_redir_pc = 32'd0;
    set_knobs(100, 100, 100, 0, 0);

    // Streaming: grant always, one-cycle response, decoder always ready.
    do_reset();
    for (int i = 0; i < 12; i++) run_cycle();
    check_eq("s1_pops", n_pops, 32'd10);
    check_eq("s1_first_addr", g_addrs[0], RESET_PC);
`ifdef IFQ_PERF_COUNTERS_EN
    check_eq("s1_perf_fetched", perf_fetched, 32'd10);
    check_eq("s1_perf_stall", perf_stall, 32'd2);
`endif

    // Credit limit: decoder stalled, memory always grants.
    do_reset();
    set_knobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 12; i++) run_cycle();
    check_eq("s2_grants", g_addrs.size(), 32'd4);
    check_eq("s2_req_low", {31'd0, imem_req}, 32'd0);
    check_eq("s2_head", instruction, 32'h0080_1234);

    // Redirect with three requests in flight; their responses must be dropped.
    do_reset();
    set_knobs(100, 100, 100, 0, 0);
    hold_resp = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    k_gnt = 0; f_redir = 1'b1; f_redir_pc = 32'h0000_0100;
    run_cycle();
    f_redir = 1'b0; hold_resp = 1'b0;
    for (int i = 0; i < 5; i++) run_cycle();
    check_eq("s3_no_stale", n_pops, 32'd0);
    k_gnt = 100;
    for (int i = 0; i < 10; i++) run_cycle();
    check_eq("s3_ngrants", g_addrs.size() >= 4, 32'd1);
    check_eq("s3_next_addr", g_addrs[3], 32'h0000_0100);
    check_eq("s3_first_pc", popped_q[0], 32'h0000_0100);

    // Randomized traffic with varied grant, latency, ready and redirect rates.
    for (int ph = 0; ph < 10; ph++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(10, 100),
                $urandom_range(0, 8), $urandom_range(0, 4));
      for (int i = 0; i < 300; i++) run_cycle();
    end
    check_eq("rnd_progress", n_pops > 100, 32'd1);

    // Reset in the middle of traffic, then restart at RESET_PC.
    set_knobs(100, 100, 50, 0, 2);
    for (int i = 0; i < 7; i++) run_cycle();
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle();
    check_eq("s5_first_addr", g_addrs[0], RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
